// File: rtl/srat_reg_dump.sv
// srat_reg_dump: debug-port register sweeper for schoolRISCV, streaming (addr, value) beats
// with an optional diff mode that emits only registers changed since the last dump.
module srat_reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        diff_mode,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        cpu_hold,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d, oaddr_q, oaddr_d;
    logic [31:0] odata_q, odata_d;
    logic        valid_q, valid_d, diff_q, diff_d;
    logic [31:0] shadow_q [32];
    logic [31:0] sv_q;
    logic        last, skip;

    assign last = addr_q == 5'(LAST_REG);
    // compares against the shadow as it was before this cycle's write
    assign skip = diff_q && sv_q[addr_q] && shadow_q[addr_q] == regData;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        valid_d = valid_q;
        diff_d  = diff_q;
        case (state_q)
            IDLE: if (start) begin
                diff_d  = diff_mode;
                addr_d  = 5'(FIRST_REG);
                state_d = READ;
            end
            READ: begin
                oaddr_d = addr_q;
                odata_d = regData;
                if (!skip) begin
                    valid_d = 1'b1;
                    state_d = SEND;
                end else if (last) state_d = DONE;
                else addr_d = addr_q + 5'd1;
            end
            SEND: if (out_ready) begin
                valid_d = 1'b0;
                state_d = last ? DONE : READ;
                addr_d  = last ? addr_q : addr_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
            valid_q <= 1'b0;
            diff_q  <= 1'b0;
            sv_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            valid_q <= valid_d;
            diff_q  <= diff_d;
            if (state_q == READ) sv_q[addr_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == READ) shadow_q[addr_q] <= regData;
    end

    assign regAddr   = addr_q;
    assign busy      = state_q != IDLE;
    assign cpu_hold  = busy;
    assign done      = state_q == DONE;
    assign out_valid = valid_q;
    assign out_addr  = oaddr_q;
    assign out_data  = odata_q;
endmodule

// File: tb/tb_srat_reg_dump.sv
// tb_srat_reg_dump: randomized bench for srat_reg_dump; two instances (full range and 4..6)
// checked against a dump-level model of expected beats, cycle counts and shadow state.
module tb_srat_reg_dump;
    logic        clk = 1'b0;
    logic        rst   [2];
    logic        start [2];
    logic        diff  [2];
    logic        ready [2];
    logic [4:0]  raddr [2];
    logic [4:0]  oaddr [2];
    logic [31:0] rdata [2];
    logic [31:0] odata [2];
    logic        hold  [2];
    logic        valid [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] core  [32];
    logic [31:0] m_sh  [2][32];
    bit          m_val [2][32];
    int          first_r [2] = '{0, 4};
    int          last_r  [2] = '{31, 6};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rdata[0] = core[raddr[0]];
    assign rdata[1] = core[raddr[1]];

    srat_reg_dump u_full (
        .clk(clk), .rst(rst[0]), .start(start[0]), .diff_mode(diff[0]),
        .regAddr(raddr[0]), .regData(rdata[0]), .cpu_hold(hold[0]),
        .out_valid(valid[0]), .out_ready(ready[0]), .out_addr(oaddr[0]),
        .out_data(odata[0]), .busy(busy[0]), .done(done[0])
    );

    srat_reg_dump #(.FIRST_REG(4), .LAST_REG(6)) u_part (
        .clk(clk), .rst(rst[1]), .start(start[1]), .diff_mode(diff[1]),
        .regAddr(raddr[1]), .regData(rdata[1]), .cpu_hold(hold[1]),
        .out_valid(valid[1]), .out_ready(ready[1]), .out_addr(oaddr[1]),
        .out_data(odata[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_valid"}, 32'(valid[u]), 0);
        chk({tag, "_hold"}, 32'(hold[u]), 0);
        chk({tag, "_busy"}, 32'(busy[u]), 0);
        chk({tag, "_done"}, 32'(done[u]), 0);
    endtask

    task automatic do_reset(input int u);
        rst[u] = 1'b0;
        start[u] = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle(u, "rst");
        chk("rst_raddr", 32'(raddr[u]), 0);
        chk("rst_oaddr", 32'(oaddr[u]), 0);
        chk("rst_odata", odata[u], 0);
        rst[u] = 1'b1;
        start[u] = 1'b0;
        for (int a = 0; a < 32; a++) m_val[u][a] = 0;
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy[u]), 0);
    endtask

    // mode: 0 ready high, 1 random ready, 2 ready low for 7 cycles on the fourth register
    task automatic run(input int u, input bit dm, input int mode, input int start_at);
        int          exp_a [$];
        logic [31:0] exp_d [$];
        int          n, cyc, stalls, stall_left;
        bit          pv, pr, rd;
        logic [4:0]  pa;
        logic [31:0] pd;
        n = 0;
        for (int a = first_r[u]; a <= last_r[u]; a++) begin
            if (!(dm && m_val[u][a] && m_sh[u][a] == core[a])) begin
                exp_a.push_back(a);
                exp_d.push_back(core[a]);
            end
            m_sh[u][a] = core[a];
            m_val[u][a] = 1;
            n++;
        end
        n += exp_a.size();
        diff[u] = dm;
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        diff[u] = 1'b0;
        cyc = 0; stalls = 0; stall_left = 7; pv = 0; pr = 0; pa = '0; pd = '0;
        while (!done[u] && cyc < 400) begin
            chk("hold", 32'(hold[u]), 1);
            chk("busy", 32'(busy[u]), 1);
            if (!dm && cyc < 2) chk("latency", 32'(valid[u]), 32'(cyc == 1));
            if (pv && !pr) begin
                chk("stall_valid", 32'(valid[u]), 1);
                chk("stall_addr", 32'(oaddr[u]), 32'(pa));
                chk("stall_data", odata[u], pd);
            end
            rd = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                 !(valid[u] && 32'(oaddr[u]) == first_r[u] + 3 && stall_left > 0);
            if (mode == 2 && valid[u] && !rd) stall_left--;
            ready[u] = rd;
            if (valid[u] && rd) begin
                if (exp_a.size() == 0) chk("extra_beat", 32'(oaddr[u]), 32'hffff_ffff);
                else begin
                    chk("beat_addr", 32'(oaddr[u]), 32'(exp_a.pop_front()));
                    chk("beat_data", odata[u], exp_d.pop_front());
                end
            end
            if (valid[u] && !rd) stalls++;
            pv = valid[u]; pr = rd; pa = oaddr[u]; pd = odata[u];
            start[u] = cyc == start_at;
            @(negedge clk);
            cyc++;
        end
        start[u] = 1'b0;
        ready[u] = 1'b0;
        chk("done_seen", 32'(done[u]), 1);
        chk("done_valid", 32'(valid[u]), 0);
        chk("beats_missing", 32'(exp_a.size()), 0);
        chk("dump_cycles", 32'(cyc), 32'(n + stalls));
        if (mode == 2) chk("stall_len", 32'(stalls), 7);
        @(negedge clk);
        chk_idle(u, "post");
        @(negedge clk);
        chk("no_requeue", 32'(busy[u]), 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; diff[u] = 1'b0; ready[u] = 1'b0;
        end
        for (int a = 0; a < 32; a++) core[a] = $urandom;
        core[0] = 32'h10;
        core[1] = 32'd5;
        core[7] = 32'd0;
        @(negedge clk);
        do_reset(0);
        do_reset(1);
        run(0, 1'b1, 0, -1);
        run(0, 1'b0, 0, -1);
        run(0, 1'b0, 2, -1);
        core[7] = 32'h1234;
        run(0, 1'b1, 0, -1);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) core[$urandom_range(0, 31)] = $urandom;
            run(0, 1'($urandom_range(0, 1)), 1, -1);
        end
        run(1, 1'b0, 0, 2);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy[1]), 1);
        chk("abort_valid_before", 32'(valid[1]), 1);
        rst[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        for (int a = 0; a < 32; a++) m_val[1][a] = 0;
        chk_idle(1, "abort");
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done[1]), 0);
        end
        run(1, 1'b1, 1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
